sync_fifo_param: RTL

//  Parametrised single-clock FIFO; next generation of the 8x9 FIFO.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr.sv | 18 +
 rtl/sync_fifo_param.sv | 94 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, width helper and count type for the parametrised FIFO
package fifo_pkg;

    localparam int DEF_DATA_W = 9;
    localparam int DEF_DEPTH  = 8;

    // Smallest r with 2**r >= n; usable in constant expressions
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Occupancy type for the default geometry (one extra bit so DEPTH itself fits)
    typedef logic [clog2(DEF_DEPTH):0] def_cnt_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer register; low ADDR_W bits address memory, MSB tracks laps
module fifo_ptr #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W:0]   ptr
);

    // Reset and flush dominate; power-of-two depth lets the natural rollover do the wrap
    always_ff @(posedge clk) begin
        if (rst || clr) ptr <= '0;
        else if (inc)   ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read, level flags and sticky error flags
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           wr_en,
    input  logic [DATA_W-1:0]              din,
    input  logic                           rd_en,
    output logic [DATA_W-1:0]              dout,
    output logic                           dout_valid,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [clog2(DEPTH):0]          count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  wr_ptr, rd_ptr, cnt_nxt;
    logic              rd_acc, wr_acc, flush;

    // A full FIFO still takes a write when a read frees the slot in the same cycle
    assign flush  = rst || clr;
    assign rd_acc = !flush && rd_en && !empty;
    assign wr_acc = !flush && wr_en && (!full || rd_acc);

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    // Wrap-bit pointers make the difference the exact occupancy 0..DEPTH
    assign count = wr_ptr - rd_ptr;

    // Occupancy after this edge; flags are registered from it so they line up with count
    always_comb begin
        cnt_nxt = flush ? '0 : count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    // Storage: written synchronously, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

    // Registered read port; dout holds between reads and across a flush
    always_ff @(posedge clk) begin
        if (rst)         dout <= '0;
        else if (rd_acc) dout <= mem[rd_ptr[ADDR_W-1:0]];
        dout_valid <= rd_acc;
    end

    // Level flags from next occupancy
    always_ff @(posedge clk) begin
        full         <= cnt_nxt == CNT_W'(DEPTH);
        empty        <= cnt_nxt == '0;
        almost_full  <= !flush && (cnt_nxt >= CNT_W'(AF_LVL));
        almost_empty <= cnt_nxt <= CNT_W'(AE_LVL);
    end

    // Sticky error flags; a flush cycle ignores requests so it never sets them
    always_ff @(posedge clk) begin
        if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  || (wr_en && full && !rd_acc);
            underflow <= underflow || (rd_en && empty);
        end
    end

endmodule
